// File: rtl/run_monitor.sv
// Passive run monitor: counts RUN cycles, detects halt (PC stuck) or timeout, and captures watched register writes.
// Optional per-channel write counters are built when RUN_MONITOR_WRCNT_EN is defined.
module run_monitor #(
    parameter int                            PC_W        = 32,
    parameter int                            DATA_W      = 32,
    parameter int                            ADDR_W      = 5,
    parameter int                            NUM_WATCH   = 2,
    parameter logic [NUM_WATCH*ADDR_W-1:0]   WATCH_LIST  = {5'd21, 5'd22},
    parameter int                            STALL_LIMIT = 4,
    parameter int                            CNT_W       = 32,
    parameter int                            TIMEOUT     = 65535
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          clear,
    input  logic [PC_W-1:0]               prgmc,
    input  logic                          rf_we,
    input  logic [ADDR_W-1:0]             rf_waddr,
    input  logic [DATA_W-1:0]             rf_wdata,
    output logic                          busy,
    output logic                          done,
    output logic                          timeout,
    output logic [CNT_W-1:0]              cycles,
    output logic [NUM_WATCH*DATA_W-1:0]   result,
    output logic [NUM_WATCH-1:0]          wr_seen,
    output logic [NUM_WATCH*8-1:0]        wr_count
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2,
        ST_TMO    = 2'd3
    } state_t;

    localparam int                 STALL_W    = $clog2(STALL_LIMIT + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT - 2);
    localparam logic [CNT_W-1:0]   CYC_LAST   = CNT_W'(TIMEOUT - 1);

    state_t                        state_r;
    state_t                        state_s;
    logic                          busy_r;
    logic                          done_r;
    logic                          timeout_r;
    logic [PC_W-1:0]               pc_prev_r;
    logic [STALL_W-1:0]            stall_cnt_r;
    logic [CNT_W-1:0]              cycles_r;
    logic [NUM_WATCH*DATA_W-1:0]   result_r;
    logic [NUM_WATCH-1:0]          wr_seen_r;
    logic [NUM_WATCH-1:0]          hit_s;
    logic                          pc_same_s;
    logic                          halt_s;
    logic                          tmo_s;
    logic                          start_run_s;
    logic                          run_s;

    assign busy    = busy_r;
    assign done    = done_r;
    assign timeout = timeout_r;
    assign cycles  = cycles_r;
    assign result  = result_r;
    assign wr_seen = wr_seen_r;

    // Run qualifiers; clear overrides everything, including the run-time updates on its edge.
    always_comb begin
        pc_same_s   = (prgmc == pc_prev_r);
        halt_s      = pc_same_s && (stall_cnt_r == STALL_LAST);
        tmo_s       = (cycles_r == CYC_LAST);
        start_run_s = (state_r == ST_IDLE) && start && !clear;
        run_s       = (state_r == ST_RUN) && !clear;
    end

    // Per-channel address match against the watch list (duplicates match independently).
    always_comb begin
        hit_s = '0;
        for (int k = 0; k < NUM_WATCH; k++) begin
            hit_s[k] = rf_we && (rf_waddr == WATCH_LIST[k*ADDR_W +: ADDR_W]);
        end
    end

    // Next-state logic; halt takes priority over timeout on the same edge.
    always_comb begin
        state_s = state_r;
        if (clear) begin
            state_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_s = ST_RUN;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (halt_s) begin
                        state_s = ST_HALTED;
                    end else if (tmo_s) begin
                        state_s = ST_TMO;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_HALTED: state_s = ST_HALTED;
                ST_TMO:    state_s = ST_TMO;
                default:   state_s = ST_IDLE;
            endcase
        end
    end

    // State register with registered status decodes of the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= ST_IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_s;
            busy_r    <= (state_s == ST_RUN);
            done_r    <= (state_s == ST_HALTED);
            timeout_r <= (state_s == ST_TMO);
        end
    end

    // Cycle counter and PC stall tracker.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycles_r    <= '0;
            pc_prev_r   <= '0;
            stall_cnt_r <= '0;
        end else if (start_run_s) begin
            cycles_r    <= '0;
            pc_prev_r   <= prgmc;
            stall_cnt_r <= '0;
        end else if (run_s) begin
            cycles_r  <= cycles_r + CNT_W'(1);
            pc_prev_r <= prgmc;
            if (pc_same_s) begin
                stall_cnt_r <= stall_cnt_r + STALL_W'(1);
            end else begin
                stall_cnt_r <= '0;
            end
        end
    end

    // Watch-channel capture; values persist after the run until the next start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_r  <= '0;
            wr_seen_r <= '0;
        end else if (start_run_s) begin
            result_r  <= '0;
            wr_seen_r <= '0;
        end else if (run_s) begin
            for (int k = 0; k < NUM_WATCH; k++) begin
                if (hit_s[k]) begin
                    result_r[k*DATA_W +: DATA_W] <= rf_wdata;
                    wr_seen_r[k]                 <= 1'b1;
                end
            end
        end
    end

`ifdef RUN_MONITOR_WRCNT_EN
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'd255) begin
            sat_inc8 = 8'd255;
        end else begin
            sat_inc8 = v + 8'd1;
        end
    endfunction

    logic [NUM_WATCH*8-1:0] wr_count_r;
    assign wr_count = wr_count_r;

    // Saturating per-channel write counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_count_r <= '0;
        end else if (start_run_s) begin
            wr_count_r <= '0;
        end else if (run_s) begin
            for (int k = 0; k < NUM_WATCH; k++) begin
                if (hit_s[k]) begin
                    wr_count_r[k*8 +: 8] <= sat_inc8(wr_count_r[k*8 +: 8]);
                end
            end
        end
    end
`else
    assign wr_count = '0;
`endif

endmodule
